operand_fetch: RTL
==================

// Module: operand_fetch
// PURPOSE
//  Register-read stage directly upstream of alu. Accepts a 32-bit MIPS instruction, reads GPR[rs]/GPR[rt]
//  from an internal 32x32 register file and presents {instruction, regA, regB} to the ALU.
//  One registered output slot plus one skid slot, valid/ready on both sides.
//  Same-cycle writeback bypass. Held operands snoop writebacks, so they are never stale.
// PARAMETERS
//  DATA_W   32  register/operand width
//  NREGS    32  number of GPRs; register 0 reads as zero
//  ADDR_W   5   register index width (log2 NREGS)
// PORTS
//  clk        in   1       clock, rising edge
//  reset      in   1       asynchronous, active-high reset
//  flush      in   1       synchronous drop of all held entries
//  in_valid   in   1       upstream instruction valid
//  in_ready   out  1       stage can accept (registered: !skid_valid)
//  in_instr   in   32      instruction; rs=[25:21], rt=[20:16]
//  wb_en      in   1       writeback enable
//  wb_addr    in   ADDR_W  writeback register index
//  wb_data    in   DATA_W  writeback data
//  out_valid  out  1       {out_instr,out_regA,out_regB} valid to ALU
//  out_ready  in   1       ALU/downstream consumes this cycle
//  out_instr  out  32      instruction passed to alu.instruction
//  out_regA   out  DATA_W  GPR[rs] -> alu.regA
//  out_regB   out  DATA_W  GPR[rt] -> alu.regB
// BEHAVIOUR
//  Reset (async, any time): all GPRs=0; out_valid=0; skid_valid=0; in_ready=1; out_instr/regA/regB=0.
//    In-flight entries are lost.
//  Regfile: at edge, if wb_en && wb_addr!=0 then GPR[wb_addr]<=wb_data. Writes to r0 are ignored; r0 always reads 0.
//  Operand read (comb): val(r) = (r==0) ? 0 : (wb_en && wb_addr==r) ? wb_data : GPR[r].
//    This gives same-cycle write-then-read bypass.
//  Accept = in_valid && in_ready. Latency: accepted at edge N -> visible on out_* after edge N.
//  Slot update at each edge, evaluated in priority order:
//    1. flush=1: out_valid<=0, skid_valid<=0. Any accept that cycle is dropped. The regfile write still occurs.
//    2. out free (!out_valid || out_ready):
//       - skid_valid: out<=skid, skid_valid<=0.
//       - else accept: out<=new entry, out_valid<=1.
//       - else: out_valid<=0.
//    3. out stalled and accept: skid<=new entry, skid_valid<=1.
//  No accept can coincide with skid_valid, because in_ready=0 then.
//  Ordering is strict FIFO. No entry is lost or duplicated under any out_ready pattern.
//  Snoop: every operand register written or held at an edge takes the value as modified by that edge's writeback.
//    - Holding entry with rs==wb_addr!=0 and wb_en: regA<=wb_data.
//    - Same rule for rt/regB.
//    - Moving skid->out applies the same snoop to the moved values.
//  No hazard stalling is performed; correctness relies on bypass+snoop.
//    Load-use hazards belong to the upstream stage.
//  out_* stay stable while out_valid && !out_ready, except for snoop updates.
//  Invalid slots hold don't-care data; the bench checks data only when the slot is valid.
// TESTING
//  1. Reset mid-stall (out+skid full): assert reset -> out_valid=0, in_ready=1 immediately; GPR5 reads 0 afterwards.
//  2. Write r3=0x7FFFFFFF, r4=1; issue ADD rs=3 rt=4, out_ready=1 -> next cycle out_valid=1, out_regA=0x7FFFFFFF,
//     out_regB=0x00000001, out_instr identical to the issued ADD.
//  3. Same cycle: wb r7=0xDEADBEEF and issue rs=7 -> out_regA=0xDEADBEEF. Write r0=5, read rs=0 -> out_regA=0.
//  4. out_ready=0; issue I1, I2 -> I1 in out, I2 in skid, in_ready=0; I3 held upstream.
//     Raise out_ready -> I1, I2, I3 emerge on consecutive cycles, no gaps/dups.
//  5. Hold rs=9 entry stalled; wb r9=0x00001234 -> out_regA=0x00001234 next cycle. Same check for an entry in skid.
//  6. flush with out+skid full and in_valid=1 -> next cycle out_valid=0, in_ready=1; the dropped instruction never appears.

Source files
------------

// File: rtl/operand_fetch.sv
// Register-read stage: 32xDATA_W GPR file with same-cycle writeback bypass, feeding a
// one-entry output slot plus one skid slot whose held operands track later writebacks.
module operand_fetch #(
    parameter int DATA_W = 32,
    parameter int NREGS  = 32,
    parameter int ADDR_W = 5
) (
    input  logic              clk,
    input  logic              reset,
    input  logic              flush,
    input  logic              in_valid,
    output logic              in_ready,
    input  logic [31:0]       in_instr,
    input  logic              wb_en,
    input  logic [ADDR_W-1:0] wb_addr,
    input  logic [DATA_W-1:0] wb_data,
    output logic              out_valid,
    input  logic              out_ready,
    output logic [31:0]       out_instr,
    output logic [DATA_W-1:0] out_regA,
    output logic [DATA_W-1:0] out_regB
);

    typedef struct packed {
        logic [31:0]       instr;
        logic [DATA_W-1:0] rega;
        logic [DATA_W-1:0] regb;
    } ent_t;

    logic [DATA_W-1:0] gpr [NREGS];
    ent_t              out_q, skid_q, new_e, out_sn, skid_sn;
    logic              skid_valid;
    logic              accept;
    logic [ADDR_W-1:0] rs, rt;

    function automatic logic hit(input logic [ADDR_W-1:0] r, input logic we,
                                 input logic [ADDR_W-1:0] wa);
        return we && (wa == r) && (r != '0);
    endfunction

    // Overlay this cycle's writeback onto an entry; serves as both bypass and snoop.
    function automatic ent_t snoop(input ent_t e, input logic we,
                                   input logic [ADDR_W-1:0] wa, input logic [DATA_W-1:0] wd);
        ent_t s;
        s = e;
        if (hit(e.instr[21 +: ADDR_W], we, wa)) s.rega = wd;
        if (hit(e.instr[16 +: ADDR_W], we, wa)) s.regb = wd;
        return s;
    endfunction

    assign rs       = in_instr[21 +: ADDR_W];
    assign rt       = in_instr[16 +: ADDR_W];
    assign in_ready = !skid_valid;
    assign accept   = in_valid && in_ready;

    always_comb begin
        new_e.instr = in_instr;
        new_e.rega  = (rs == '0) ? '0 : gpr[rs];
        new_e.regb  = (rt == '0) ? '0 : gpr[rt];
        new_e       = snoop(new_e, wb_en, wb_addr, wb_data);
        out_sn      = snoop(out_q, wb_en, wb_addr, wb_data);
        skid_sn     = snoop(skid_q, wb_en, wb_addr, wb_data);
    end

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            for (int i = 0; i < NREGS; i++) gpr[i] <= '0;
        end else if (wb_en && wb_addr != '0) begin
            gpr[wb_addr] <= wb_data;
        end
    end

    // Held slots always take their snooped value; the priority chain overrides the loads.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            out_valid  <= 1'b0;
            skid_valid <= 1'b0;
            out_q      <= '0;
            skid_q     <= '0;
        end else begin
            out_q  <= out_sn;
            skid_q <= skid_sn;
            if (flush) begin
                out_valid  <= 1'b0;
                skid_valid <= 1'b0;
            end else if (!out_valid || out_ready) begin
                if (skid_valid) begin
                    out_q      <= skid_sn;
                    skid_valid <= 1'b0;
                end else if (accept) begin
                    out_q     <= new_e;
                    out_valid <= 1'b1;
                end else begin
                    out_valid <= 1'b0;
                end
            end else if (accept) begin
                skid_q     <= new_e;
                skid_valid <= 1'b1;
            end
        end
    end

    assign out_instr = out_q.instr;
    assign out_regA  = out_q.rega;
    assign out_regB  = out_q.regb;

endmodule
